registers_unit_mp: RTL and testbench
====================================

REGISTERS_UNIT_MP -- requirements
Module: registers_unit_mp

Interface
REQ-001 Parameter XLEN, 32, register data width in bits.
REQ-002 Parameter NREG, 32, number of architectural registers (power of 2, >=4); AW = clog2(NREG).
REQ-003 Parameter NRD, 2, number of independent read ports (1..4).
REQ-004 Parameter SP_INIT, 1024, reset value of register 2 (stack pointer).
REQ-005 Parameter OBS_IDX, 10, index of register continuously driven on ObsReg.
REQ-006 Clk  in  1  single clock; all state updates on rising edge.
REQ-007 Rst  in  1  reset, asynchronous, active-high.
REQ-008 RdAddr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
REQ-009 RdData  out  NRD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
REQ-010 RUWr  in  1  write enable.
REQ-011 WrAddr  in  AW  write destination index.
REQ-012 WrData  in  XLEN  write data.
REQ-013 IssueVld  in  1  marks IssueRd as pending (scoreboard set).
REQ-014 IssueRd  in  AW  destination index of the issued instruction.
REQ-015 Busy  out  NREG  scoreboard; bit i = register i has a pending write.
REQ-016 DbgReq  in  1  debug read request, level, held until DbgAck.
REQ-017 DbgAddr  in  AW  debug read index, stable while DbgReq high.
REQ-018 DbgAck  out  1  one-cycle debug completion pulse.
REQ-019 DbgData  out  XLEN  captured debug data, held until next capture.
REQ-020 ObsReg  out  XLEN  contents of register OBS_IDX.

Function
REQ-021 Reads SHALL be combinational; RdData port k = register[RdAddr k]; index 0 always reads 0.
REQ-022 On rising edge with RUWr=1 and WrAddr!=0, register[WrAddr] SHALL take WrData; writes to index 0 SHALL be discarded.
REQ-023 Busy[i] SHALL set on edge with IssueVld=1 and IssueRd=i!=0; SHALL clear on edge with RUWr=1 and WrAddr=i.
REQ-024 Simultaneous set and clear of the same index SHALL leave Busy[i]=1 (new producer wins); Busy[0] SHALL always be 0.
REQ-025 Debug FSM states IDLE, ACK, DRAIN: IDLE + DbgReq -> capture register[DbgAddr] into DbgData, go ACK.
REQ-026 ACK: DbgAck=1 for exactly that cycle, go DRAIN; DRAIN: stay until DbgReq=0, then IDLE.
REQ-027 Debug capture SHALL see a same-edge write only under RU_BYPASS_EN rules (REQ-033); debug never blocks reads or writes.
REQ-028 ObsReg SHALL follow register[OBS_IDX] with same visibility rules as a read port.

Reset
REQ-029 Rst=1 SHALL immediately, independent of Clk, set all registers to 0 except register 2 = SP_INIT.
REQ-030 Rst=1 SHALL clear Busy to 0, DbgData to 0, DbgAck to 0, and force FSM to IDLE.
REQ-031 Reset asserted mid debug transaction SHALL abort it; no DbgAck SHALL be produced for it after release.
REQ-032 First write/issue SHALL take effect on the first rising edge with Rst=0.

Configuration
REQ-033 Macro RU_BYPASS_EN defined: any read port, ObsReg, or debug capture whose index equals WrAddr (!=0) while RUWr=1 SHALL return WrData in the same cycle.
REQ-034 RU_BYPASS_EN undefined: those paths SHALL return the stored (old) value; new value visible the cycle after the write edge.

Verification
REQ-035 Release reset -> reg2 reads 1024, all others 0, Busy=0, DbgAck=0, ObsReg=0.
REQ-036 RUWr=1, WrAddr=10, WrData=0xDEADBEEF, RdAddr0=10 same cycle -> bypass: 0xDEADBEEF immediately; no bypass: 0 then 0xDEADBEEF next cycle; ObsReg matches.
REQ-037 Write 0x55 to x0, then read x0 on all ports -> 0; Busy[0] stays 0 after IssueVld with IssueRd=0.
REQ-038 IssueVld IssueRd=5, later same-edge IssueRd=5 and RUWr WrAddr=5 -> Busy[5] stays 1; next write to 5 alone -> Busy[5]=0.
REQ-039 Reg 7=0x1234, DbgReq=1 DbgAddr=7 held 4 cycles -> DbgAck single pulse one cycle after request, DbgData=0x1234, no second ack until DbgReq drops and rises.
REQ-040 DbgReq=1 then Rst pulsed during ACK cycle -> DbgAck=0, DbgData=0, FSM IDLE; NRD=4 build reads four distinct registers correctly in one cycle.

Source files
------------

// File: rtl/registers_unit_mp_if.sv
// registers_unit_mp_if -- bundle of the register-file read, write, scoreboard,
// debug and observation signals. The slave modport is the register unit; the
// master modport is whatever drives it (pipeline or testbench).
interface registers_unit_mp_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = $clog2(NREG);

   // read ports
   logic [NRD*AW-1:0]   RdAddr;
   logic [NRD*XLEN-1:0] RdData;

   // write port
   logic                RUWr;
   logic [AW-1:0]       WrAddr;
   logic [XLEN-1:0]     WrData;

   // scoreboard
   logic                IssueVld;
   logic [AW-1:0]       IssueRd;
   logic [NREG-1:0]     Busy;

   // debug read channel
   logic                DbgReq;
   logic [AW-1:0]       DbgAddr;
   logic                DbgAck;
   logic [XLEN-1:0]     DbgData;

   // observation tap
   logic [XLEN-1:0]     ObsReg;

   modport slave (
      input  RdAddr,
      input  RUWr,
      input  WrAddr,
      input  WrData,
      input  IssueVld,
      input  IssueRd,
      input  DbgReq,
      input  DbgAddr,
      output RdData,
      output Busy,
      output DbgAck,
      output DbgData,
      output ObsReg
   );

   modport master (
      output RdAddr,
      output RUWr,
      output WrAddr,
      output WrData,
      output IssueVld,
      output IssueRd,
      output DbgReq,
      output DbgAddr,
      input  RdData,
      input  Busy,
      input  DbgAck,
      input  DbgData,
      input  ObsReg
   );
endinterface

// File: rtl/registers_unit_mp.sv
// registers_unit_mp -- multi-port architectural register file with a
// pending-write scoreboard, a handshaked debug read channel and a fixed
// observation tap. Register 0 is hard-wired to zero; register 2 resets to
// SP_INIT (stack pointer).
//
// Optional feature: define RU_BYPASS_EN to forward a same-cycle write to every
// read port, the observation tap and the debug capture. Without it those paths
// return the stored value and a write becomes visible the cycle after its edge.
module registers_unit_mp #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter int SP_INIT = 1024,
   parameter int OBS_IDX = 10
) (
   input  logic                Clk,
   input  logic                Rst,
   registers_unit_mp_if.slave  bus
);
   localparam int AW = $clog2(NREG);

   // Debug FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACK   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // ------------------------------------------------------------------
   // Storage and per-register views
   // ------------------------------------------------------------------
   // reg_val: the stored contents; rd_view: what any reader sees this cycle
   // (stored value, or the in-flight write data when forwarding is built in).
   logic [XLEN-1:0] reg_val [NREG];
   logic [XLEN-1:0] rd_view [NREG];
   logic [NREG-1:0] wr_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            // index 0 holds no state and never reports a write hit
            assign wr_hit[gi]  = 1'b0;
            assign reg_val[gi] = '0;
            assign rd_view[gi] = '0;
         end else begin : g_store
            logic [XLEN-1:0] data_q;

            assign wr_hit[gi]  = bus.RUWr && (bus.WrAddr == AW'(gi));
            assign reg_val[gi] = data_q;

            // Register storage: async reset to its architectural reset value,
            // then load WrData whenever this index is the write target.
            always_ff @(posedge Clk or posedge Rst) begin
               if (Rst) begin
                  data_q <= (gi == 2) ? XLEN'(SP_INIT) : '0;
               end else if (wr_hit[gi]) begin
                  data_q <= bus.WrData;
               end
            end

`ifdef RU_BYPASS_EN
            assign rd_view[gi] = wr_hit[gi] ? bus.WrData : data_q;
`else
            assign rd_view[gi] = data_q;
`endif
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Combinational read ports and observation tap
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         assign bus.RdData[gi*XLEN +: XLEN] = rd_view[bus.RdAddr[gi*AW +: AW]];
      end
   endgenerate

   assign bus.ObsReg = rd_view[OBS_IDX];

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   // Next scoreboard: clear the retiring writer, then set the new producer so
   // that a same-edge issue and write to one index leaves it pending.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (bus.IssueVld) begin
         set_mask = NREG'(1) << bus.IssueRd;
      end
      if (bus.RUWr) begin
         clr_mask = NREG'(1) << bus.WrAddr;
      end
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   // Scoreboard state register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign bus.Busy = busy_q;

   // ------------------------------------------------------------------
   // Debug read channel
   // ------------------------------------------------------------------
   logic [1:0]      dbg_state_q;
   logic [1:0]      dbg_state_d;
   logic [XLEN-1:0] dbg_data_q;
   logic [XLEN-1:0] dbg_data_d;

   // Debug FSM next state: capture on a request seen in IDLE, acknowledge for
   // one cycle, then wait for the requester to drop DbgReq before rearming.
   always_comb begin
      dbg_state_d = dbg_state_q;
      dbg_data_d  = dbg_data_q;
      case (dbg_state_q)
         ST_IDLE: begin
            if (bus.DbgReq) begin
               dbg_data_d  = rd_view[bus.DbgAddr];
               dbg_state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            dbg_state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!bus.DbgReq) begin
               dbg_state_d = ST_IDLE;
            end
         end
         default: begin
            dbg_state_d = ST_IDLE;
         end
      endcase
   end

   // Debug FSM and capture registers; reset aborts any open transaction.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         dbg_state_q <= ST_IDLE;
         dbg_data_q  <= '0;
      end else begin
         dbg_state_q <= dbg_state_d;
         dbg_data_q  <= dbg_data_d;
      end
   end

   assign bus.DbgAck  = (dbg_state_q == ST_ACK);
   assign bus.DbgData = dbg_data_q;

endmodule

// File: tb/tb_registers_unit_mp.sv
// tb_registers_unit_mp -- directed scenarios followed by random traffic, all
// checked against a behavioural register-file model kept in this bench.
module tb_registers_unit_mp;
   localparam int XLEN    = 32;
   localparam int NREG    = 32;
   localparam int NRD     = 4;
   localparam int AW      = 5;
   localparam int SP_INIT = 1024;
   localparam int OBS_IDX = 10;
`ifdef RU_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   registers_unit_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

   registers_unit_mp #(
      .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .SP_INIT(SP_INIT), .OBS_IDX(OBS_IDX)
   ) dut (
      .Clk(clk),
      .Rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [XLEN-1:0] m_reg [NREG];
   logic [NREG-1:0] m_busy;
   logic            m_ack;    // acknowledge expected this cycle
   logic            m_txn;    // a debug transaction is open
   logic [XLEN-1:0] m_dbg;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // what a reader of index idx should see right now
   function automatic logic [XLEN-1:0] m_read(input int idx);
      if (idx == 0) return '0;
      if (BYP && bus.RUWr && (int'(bus.WrAddr) == idx)) return bus.WrData;
      return m_reg[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      m_reg[2] = XLEN'(SP_INIT);
      m_busy   = '0;
      m_ack    = 1'b0;
      m_txn    = 1'b0;
      m_dbg    = '0;
   endtask

   // apply the effect of one rising edge using the inputs present at it
   task automatic model_edge();
      logic [XLEN-1:0] cap;
      cap = m_read(int'(bus.DbgAddr));
      if (!m_txn && bus.DbgReq) begin
         m_dbg = cap;
         m_ack = 1'b1;
         m_txn = 1'b1;
      end else if (m_ack) begin
         m_ack = 1'b0;
      end else if (m_txn && !bus.DbgReq) begin
         m_txn = 1'b0;
      end
      if (bus.RUWr) m_busy[bus.WrAddr] = 1'b0;
      if (bus.IssueVld && bus.IssueRd != 0) m_busy[bus.IssueRd] = 1'b1;
      if (bus.RUWr && bus.WrAddr != 0) m_reg[bus.WrAddr] = bus.WrData;
   endtask

   task automatic check_outputs(input string tag);
      for (int k = 0; k < NRD; k++) begin
         check_value($sformatf("%s_rd%0d", tag, k), 64'(bus.RdData[k*XLEN +: XLEN]),
                     64'(m_read(int'(bus.RdAddr[k*AW +: AW]))));
      end
      check_value({tag, "_obs"},  64'(bus.ObsReg),  64'(m_read(OBS_IDX)));
      check_value({tag, "_busy"}, 64'(bus.Busy),    64'(m_busy));
      check_value({tag, "_ack"},  64'(bus.DbgAck),  64'(m_ack));
      check_value({tag, "_dbg"},  64'(bus.DbgData), 64'(m_dbg));
   endtask

   // called at posedge+1 with inputs set: check, take the edge, update model
   task automatic step(input string tag);
      #1;
      check_outputs(tag);
      $display("txn %s wr=%b wa=%0d wd=%h iss=%b ird=%0d dreq=%b da=%0d",
               tag, bus.RUWr, bus.WrAddr, bus.WrData, bus.IssueVld, bus.IssueRd,
               bus.DbgReq, bus.DbgAddr);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic quiet_inputs();
      bus.RUWr     = 1'b0;
      bus.WrAddr   = '0;
      bus.WrData   = '0;
      bus.IssueVld = 1'b0;
      bus.IssueRd  = '0;
   endtask

   task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
      bus.RdAddr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check_value({tag, "_rst_busy"}, 64'(bus.Busy), 64'd0);
      check_value({tag, "_rst_ack"},  64'(bus.DbgAck), 64'd0);
      check_value({tag, "_rst_dbg"},  64'(bus.DbgData), 64'd0);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   initial begin
      quiet_inputs();
      bus.DbgReq  = 1'b0;
      bus.DbgAddr = '0;
      set_rd(0, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1;
      do_reset("init");

      // reset contents on all ports, four registers per cycle
      for (int i = 0; i < NREG; i += 4) begin
         set_rd(i, i + 1, i + 2, i + 3);
         step($sformatf("rstscan%0d", i));
      end
      set_rd(2, 10, 0, 1);
      #1;
      check_value("sp_init", 64'(bus.RdData[0 +: XLEN]), 64'd1024);
      check_value("obs_reset", 64'(bus.ObsReg), 64'd0);
      step("rst_idle");

      // same-cycle write and read of the observed register
      bus.RUWr = 1'b1; bus.WrAddr = 5'd10; bus.WrData = 32'hDEADBEEF;
      set_rd(10, 10, 2, 0);
      #1;
      check_value("byp_rd0", 64'(bus.RdData[0 +: XLEN]), BYP ? 64'hDEADBEEF : 64'd0);
      check_value("byp_obs", 64'(bus.ObsReg), BYP ? 64'hDEADBEEF : 64'd0);
      step("wr10");
      quiet_inputs();
      #1;
      check_value("after_rd0", 64'(bus.RdData[0 +: XLEN]), 64'hDEADBEEF);
      check_value("after_obs", 64'(bus.ObsReg), 64'hDEADBEEF);
      step("rd10");

      // x0 ignores writes and never becomes busy
      bus.RUWr = 1'b1; bus.WrAddr = 5'd0; bus.WrData = 32'h55;
      bus.IssueVld = 1'b1; bus.IssueRd = 5'd0;
      set_rd(0, 0, 0, 0);
      step("wr_x0");
      quiet_inputs();
      #1;
      for (int k = 0; k < NRD; k++)
         check_value($sformatf("x0_rd%0d", k), 64'(bus.RdData[k*XLEN +: XLEN]), 64'd0);
      check_value("busy0", 64'(bus.Busy[0]), 64'd0);
      step("rd_x0");

      // scoreboard: new producer wins over same-edge retirement
      bus.IssueVld = 1'b1; bus.IssueRd = 5'd5;
      step("iss5");
      quiet_inputs();
      step("gap");
      check_value("busy5_set", 64'(bus.Busy[5]), 64'd1);
      bus.IssueVld = 1'b1; bus.IssueRd = 5'd5;
      bus.RUWr = 1'b1; bus.WrAddr = 5'd5; bus.WrData = 32'h1;
      step("iss5_wr5");
      check_value("busy5_hold", 64'(bus.Busy[5]), 64'd1);
      quiet_inputs();
      bus.RUWr = 1'b1; bus.WrAddr = 5'd5; bus.WrData = 32'h2;
      step("wr5");
      check_value("busy5_clr", 64'(bus.Busy[5]), 64'd0);
      quiet_inputs();

      // debug read held for four cycles gives a single acknowledge
      bus.RUWr = 1'b1; bus.WrAddr = 5'd7; bus.WrData = 32'h1234;
      step("wr7");
      quiet_inputs();
      bus.DbgReq = 1'b1; bus.DbgAddr = 5'd7;
      for (int c = 0; c < 4; c++) begin
         step($sformatf("dbg_hold%0d", c));
         check_value($sformatf("dbg_ack%0d", c), 64'(bus.DbgAck), (c == 0) ? 64'd1 : 64'd0);
      end
      check_value("dbg_data7", 64'(bus.DbgData), 64'h1234);
      bus.DbgReq = 1'b0;
      step("dbg_drop");
      bus.DbgReq = 1'b1;
      step("dbg_rearm");
      check_value("dbg_ack_rearm", 64'(bus.DbgAck), 64'd1);
      bus.DbgReq = 1'b0;
      step("dbg_drop2");
      step("dbg_idle");

      // reset during the acknowledge cycle aborts the transaction
      bus.DbgReq = 1'b1; bus.DbgAddr = 5'd7;
      step("dbg_req_rst");
      bus.DbgReq = 1'b0;
      do_reset("dbg_abort");
      for (int c = 0; c < 3; c++) begin
         step($sformatf("post_rst%0d", c));
         check_value($sformatf("no_ack%0d", c), 64'(bus.DbgAck), 64'd0);
      end

      // four distinct registers read in one cycle
      for (int i = 3; i < 7; i++) begin
         bus.RUWr = 1'b1; bus.WrAddr = AW'(i); bus.WrData = 32'hA000_0000 + 32'(i);
         step($sformatf("fill%0d", i));
      end
      quiet_inputs();
      set_rd(6, 3, 5, 4);
      #1;
      check_value("quad0", 64'(bus.RdData[0*XLEN +: XLEN]), 64'hA000_0006);
      check_value("quad1", 64'(bus.RdData[1*XLEN +: XLEN]), 64'hA000_0003);
      check_value("quad2", 64'(bus.RdData[2*XLEN +: XLEN]), 64'hA000_0005);
      check_value("quad3", 64'(bus.RdData[3*XLEN +: XLEN]), 64'hA000_0004);
      step("quad");

      // random traffic
      for (int n = 0; n < 400; n++) begin
         bus.RUWr     = 1'($urandom_range(0, 1));
         bus.WrAddr   = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
         bus.WrData   = $urandom;
         bus.IssueVld = 1'($urandom_range(0, 1));
         bus.IssueRd  = ($urandom_range(0, 3) == 0) ? bus.WrAddr : AW'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            set_rd(int'(bus.WrAddr), OBS_IDX, 2, int'($urandom_range(0, NREG - 1)));
         end else begin
            set_rd(int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)));
         end
         if (!bus.DbgReq) begin
            if ($urandom_range(0, 3) == 0) begin
               bus.DbgAddr = ($urandom_range(0, 1) == 0) ? bus.WrAddr : AW'($urandom);
               bus.DbgReq  = 1'b1;
            end
         end else if ($urandom_range(0, 5) == 0) begin
            bus.DbgReq = 1'b0;
         end
         if (n == 200) begin
            do_reset("rand_rst");
         end
         step($sformatf("rnd%0d", n));
      end

      quiet_inputs();
      bus.DbgReq = 1'b0;
      step("final");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
